// File: rtl/classifier_pkg.sv
// classifier_pkg: shared classifier sizes and readout FSM state encoding
package classifier_pkg;
  localparam int N_CLASSES_DEF = 10;
  localparam int SCORE_W_DEF = 20;
  localparam int IDX_W_DEF = 4;
  typedef enum logic [2:0] {IDLE, READ, SEND, CLEAR, DONE} rd_state_t;
endpackage

// File: rtl/argmax_cmp.sv
// argmax_cmp: signed compare-and-hold of the running maximum; ties keep the earlier index
module argmax_cmp
  import classifier_pkg::*;
#(
  parameter int SCORE_W = SCORE_W_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_clr,
  input  logic                      i_en,
  input  logic                      i_load_first,
  input  logic signed [SCORE_W-1:0] i_score,
  input  logic        [IDX_W-1:0]   i_idx,
  output logic signed [SCORE_W-1:0] o_max_score,
  output logic        [IDX_W-1:0]   o_max_idx
);
  logic w_take;
  assign w_take = i_en && (i_load_first || i_score > o_max_score);
  always_ff @(posedge clk or posedge rst) begin
    if (rst || i_clr) begin
      o_max_score <= '0;
      o_max_idx <= '0;
    end else if (w_take) begin
      o_max_score <= i_score;
      o_max_idx <= i_idx;
    end
  end
endmodule

// File: rtl/score_readout_argmax.sv
// score_readout_argmax: reads class scores, optionally streams them (SCORE_READOUT_STREAM_EN), reports argmax
module score_readout_argmax
  import classifier_pkg::*;
#(
  parameter int N_CLASSES = N_CLASSES_DEF,
  parameter int SCORE_W = SCORE_W_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic        [IDX_W-1:0]   rd_idx,
  input  logic signed [SCORE_W-1:0] rd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic        [IDX_W-1:0]   out_idx,
  output logic signed [SCORE_W-1:0] out_score,
  output logic                      clr_scores,
  output logic                      done,
  output logic        [IDX_W-1:0]   class_id,
  output logic signed [SCORE_W-1:0] class_score
);
  rd_state_t r_state;
  logic w_last, w_adv;
  logic signed [SCORE_W-1:0] w_max_score;
  logic [IDX_W-1:0] w_max_idx;
`ifdef SCORE_READOUT_STREAM_EN
  assign out_valid = r_state == SEND;
  assign w_adv = out_valid && out_ready;
`else
  logic w_unused_ready;
  assign w_unused_ready = out_ready;
  assign out_valid = 1'b0;
  assign w_adv = r_state == READ;
`endif
  assign w_last = rd_idx == IDX_W'(N_CLASSES - 1);
  assign busy = r_state != IDLE;
  assign clr_scores = r_state == CLEAR;
  assign done = r_state == DONE;
  argmax_cmp #(.SCORE_W(SCORE_W), .IDX_W(IDX_W)) u_cmp (
    .clk(clk),
    .rst(rst),
    .i_clr(r_state == IDLE && start),
    .i_en(r_state == READ),
    .i_load_first(rd_idx == '0),
    .i_score(rd_data),
    .i_idx(rd_idx),
    .o_max_score(w_max_score),
    .o_max_idx(w_max_idx)
  );
  // result registers load on entry to DONE so they are valid alongside the done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      rd_idx <= '0;
      out_idx <= '0;
      out_score <= '0;
      class_id <= '0;
      class_score <= '0;
    end else begin
      if (r_state == READ) begin
        out_score <= rd_data;
        out_idx <= rd_idx;
      end
      if (w_adv && !w_last) rd_idx <= rd_idx + IDX_W'(1);
      else if (r_state == IDLE && start) rd_idx <= '0;
      if (r_state == CLEAR) begin
        class_id <= w_max_idx;
        class_score <= w_max_score;
      end
      case (r_state)
        IDLE: r_state <= start ? READ : IDLE;
        READ, SEND: r_state <= w_adv ? (w_last ? CLEAR : READ) : SEND;
        CLEAR: r_state <= DONE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
